// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the dual-core data-memory arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DFLT   = 10;
    localparam int DATA_W_DFLT   = 32;
    localparam int LOCK_MAX_DFLT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_lock_watchdog.sv
// Saturating count of consecutive locked cycles; expired flags the hold limit.
module lock_watchdog
    import dmem_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DFLT
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [CNT_W-1:0] count_r;

    // Count reads k during the k-th locked cycle, so expiry lands on cycle LOCK_MAX
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != CNT_W'(LOCK_MAX))) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == CNT_W'(LOCK_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-core arbiter for a single-port data RAM with bus locking and a lock watchdog.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DFLT,
    parameter int DATA_W   = DATA_W_DFLT,
    parameter int LOCK_MAX = LOCK_MAX_DFLT
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic              c0_lock,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic              c0_rvalid,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic              c1_lock,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_err
);

    arb_state_t state_r, state_nxt_s;
    logic       prio_r, prio_nxt_s;
    logic [1:0] blk_r, blk_nxt_s;
    logic [1:0] pend_r;
    logic       lock_err_r, lock_err_nxt_s;
    logic       gnt0_s, gnt1_s;
    logic       lock_next_s, expired_s;

    // Grant selection: prio breaks ties only while unlocked
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (c0_req && c1_req) begin
                    gnt0_s = ~prio_r;
                    gnt1_s = prio_r;
                end else begin
                    gnt0_s = c0_req;
                    gnt1_s = c1_req;
                end
            end
            LOCK0:   gnt0_s = c0_req;
            LOCK1:   gnt1_s = c1_req;
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
    end

    // Lock entry/exit; a forced release blocks re-locking until that core drops lock
    always_comb begin
        state_nxt_s    = state_r;
        prio_nxt_s     = prio_r;
        lock_err_nxt_s = 1'b0;
        blk_nxt_s      = blk_r & {c1_lock, c0_lock};
        case (state_r)
            IDLE: begin
                if (gnt0_s) begin
                    if (c0_lock && !blk_r[0]) state_nxt_s = LOCK0;
                    else                      prio_nxt_s  = 1'b1;
                end else if (gnt1_s) begin
                    if (c1_lock && !blk_r[1]) state_nxt_s = LOCK1;
                    else                      prio_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCK0: begin
                if (!c0_lock) begin
                    state_nxt_s = IDLE;
                    prio_nxt_s  = 1'b1;
                end else if (expired_s) begin
                    state_nxt_s    = IDLE;
                    prio_nxt_s     = 1'b1;
                    blk_nxt_s[0]   = 1'b1;
                    lock_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = LOCK0;
                end
            end
            LOCK1: begin
                if (!c1_lock) begin
                    state_nxt_s = IDLE;
                    prio_nxt_s  = 1'b0;
                end else if (expired_s) begin
                    state_nxt_s    = IDLE;
                    prio_nxt_s     = 1'b0;
                    blk_nxt_s[1]   = 1'b1;
                    lock_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = LOCK1;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    assign lock_next_s = (state_nxt_s != IDLE);

    lock_watchdog #(.LOCK_MAX(LOCK_MAX)) u_wdog (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .enable  (lock_next_s),
        .clear   (~lock_next_s),
        .expired (expired_s)
    );

    // Arbiter state, flags and read-return tracking
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= IDLE;
            prio_r     <= 1'b0;
            blk_r      <= 2'b00;
            pend_r     <= 2'b00;
            lock_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            prio_r     <= prio_nxt_s;
            blk_r      <= blk_nxt_s;
            pend_r     <= {gnt1_s & ~c1_we, gnt0_s & ~c0_we};
            lock_err_r <= lock_err_nxt_s;
        end
    end

    // Grants are combinational, so gate them with reset to keep outputs quiet in reset
    assign c0_gnt    = gnt0_s & RESET_N;
    assign c1_gnt    = gnt1_s & RESET_N;
    assign mem_en    = c0_gnt | c1_gnt;
    assign mem_we    = c0_gnt ? c0_we    : (c1_gnt ? c1_we    : 1'b0);
    assign mem_addr  = c0_gnt ? c0_addr  : (c1_gnt ? c1_addr  : {ADDR_W{1'b0}});
    assign mem_wdata = c0_gnt ? c0_wdata : (c1_gnt ? c1_wdata : {DATA_W{1'b0}});

    assign c0_rvalid = pend_r[0];
    assign c1_rvalid = pend_r[1];
    assign c0_rdata  = pend_r[0] ? mem_rdata : {DATA_W{1'b0}};
    assign c1_rdata  = pend_r[1] ? mem_rdata : {DATA_W{1'b0}};
    assign lock_err  = lock_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a behavioural arbitration model.
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LM = 16;

    typedef struct packed {
        logic          req;
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } creq_t;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    creq_t cin [2];

    logic c0_gnt, c0_rvalid, c1_gnt, c1_rvalid, mem_en, mem_we, lock_err;
    logic [DW-1:0] c0_rdata, c1_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] e_ram [0:1023];

    int total = 0;
    int bad = 0;

    // behavioural model state
    int            m_owner;
    logic          m_prio;
    int            m_held;
    logic          m_blk [2];
    logic          m_pv  [2];
    logic [DW-1:0] m_pd  [2];
    logic          m_err;
    logic [DW-1:0] m_ram [0:1023];

    logic          s_gnt0, s_gnt1, s_rvalid0, s_rvalid1, s_lock_err;
    logic [DW-1:0] s_rdata0, s_rdata1;

    dmem_arbiter dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .c0_req(cin[0].req), .c0_we(cin[0].we), .c0_lock(cin[0].lock),
        .c0_addr(cin[0].addr), .c0_wdata(cin[0].wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(cin[1].req), .c1_we(cin[1].we), .c1_lock(cin[1].lock),
        .c1_addr(cin[1].addr), .c1_wdata(cin[1].wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .lock_err(lock_err)
    );

    always #5 CLK = ~CLK;

    // RAM environment with one-cycle read latency
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) e_ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= e_ram[mem_addr];
        end
    end

    function automatic creq_t mk(input logic req, input logic we, input logic lock,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        return {req, we, lock, addr, wdata};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_owner = -1; m_prio = 1'b0; m_held = 0; m_err = 1'b0;
        for (int n = 0; n < 2; n++) begin
            m_blk[n] = 1'b0; m_pv[n] = 1'b0; m_pd[n] = '0;
        end
    endtask

    task automatic m_update(input int w);
        for (int n = 0; n < 2; n++) begin
            m_pv[n] = (w == n) && !cin[n].we;
            if (m_pv[n]) m_pd[n] = m_ram[cin[n].addr];
        end
        if (w >= 0 && cin[w].we) m_ram[cin[w].addr] = cin[w].wdata;
        m_err = 1'b0;
        if (m_owner < 0) begin
            if (w >= 0) begin
                if (cin[w].lock && !m_blk[w]) begin
                    m_owner = w; m_held = 1;
                end else begin
                    m_prio = (w == 0);
                end
            end
        end else if (!cin[m_owner].lock) begin
            m_prio = (m_owner == 0); m_owner = -1;
        end else if (m_held == LM) begin
            m_prio = (m_owner == 0); m_blk[m_owner] = 1'b1; m_err = 1'b1; m_owner = -1;
        end else begin
            m_held++;
        end
        for (int n = 0; n < 2; n++) if (!cin[n].lock) m_blk[n] = 1'b0;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model across the edge
    task automatic step(output int win);
        int w;
        @(negedge CLK);
        if (!RESET_N) w = -1;
        else if (m_owner < 0) begin
            if (cin[0].req && cin[1].req) w = int'(m_prio);
            else if (cin[0].req)          w = 0;
            else if (cin[1].req)          w = 1;
            else                          w = -1;
        end else w = cin[m_owner].req ? m_owner : -1;
        chk("gnt0", c0_gnt, w == 0);
        chk("gnt1", c1_gnt, w == 1);
        chk("mem_en", mem_en, w >= 0);
        if (w >= 0) begin
            chk("mem_we", mem_we, cin[w].we);
            chk("mem_addr", mem_addr, cin[w].addr);
            chk("mem_wdata", mem_wdata, cin[w].wdata);
        end else if (!RESET_N) begin
            chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 64'd0);
        end
        chk("rvalid0", c0_rvalid, m_pv[0]);
        chk("rdata0", c0_rdata, m_pv[0] ? m_pd[0] : 32'h0);
        chk("rvalid1", c1_rvalid, m_pv[1]);
        chk("rdata1", c1_rdata, m_pv[1] ? m_pd[1] : 32'h0);
        chk("lock_err", lock_err, m_err);
        s_gnt0 = c0_gnt; s_gnt1 = c1_gnt; s_rvalid0 = c0_rvalid; s_rvalid1 = c1_rvalid;
        s_rdata0 = c0_rdata; s_rdata1 = c1_rdata; s_lock_err = lock_err;
        if (RESET_N) m_update(w);
        win = w;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int w, pulses, pulse_at, pulse_gnt1;
        int lk_left [2];
        logic rq, lk;

        for (int i = 0; i < 1024; i++) begin
            e_ram[i] = 32'(i) * 32'h9E3779B1;
            m_ram[i] = 32'(i) * 32'h9E3779B1;
        end
        e_ram[4] = 32'hDEADBEEF;
        m_ram[4] = 32'hDEADBEEF;
        cin[0] = '0; cin[1] = '0;
        lk_left[0] = 0; lk_left[1] = 0;
        m_reset();

        // reset state
        step(w); step(w);
        RESET_N = 1'b1;
        step(w);

        // lone read returns RAM contents one cycle later
        cin[0] = mk(1'b1, 1'b0, 1'b0, 10'h004, 32'h0);
        step(w);
        chk("r034_gnt", s_gnt0, 1'b1);
        cin[0] = '0;
        step(w);
        chk("r034_rvalid", s_rvalid0, 1'b1);
        chk("r034_rdata", s_rdata0, 32'hDEADBEEF);

        // continuous requests from reset alternate with no gap
        RESET_N = 1'b0; m_reset(); step(w); RESET_N = 1'b1;
        cin[0] = mk(1'b1, 1'b0, 1'b0, 10'h001, 32'h0);
        cin[1] = mk(1'b1, 1'b0, 1'b0, 10'h002, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(w);
            chk("r035_alt", {s_gnt1, s_gnt0}, (i % 2) ? 2'b10 : 2'b01);
            if (w >= 0) cin[w].addr = 10'($urandom_range(0, 15));
        end
        cin[0] = '0; cin[1] = '0;
        step(w);

        // c1 locked write holds c0 off until lock drops
        cin[1] = mk(1'b1, 1'b1, 1'b1, 10'h010, 32'h12345678);
        step(w);
        chk("r036_c1gnt", s_gnt1, 1'b1);
        cin[1] = mk(1'b0, 1'b0, 1'b1, 10'h000, 32'h0);
        cin[0] = mk(1'b1, 1'b0, 1'b0, 10'h010, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(w);
            chk("r036_wait", s_gnt0, 1'b0);
        end
        cin[1].lock = 1'b0;
        step(w);
        chk("r036_rel", s_gnt0, 1'b0);
        step(w);
        chk("r036_gnt", s_gnt0, 1'b1);
        cin[0] = '0;
        step(w);
        chk("r036_rdata", s_rdata0, 32'h12345678);

        // watchdog forces release after LM locked cycles
        cin[0] = mk(1'b1, 1'b0, 1'b1, 10'h005, 32'h0);
        step(w);
        cin[0] = mk(1'b0, 1'b0, 1'b1, 10'h000, 32'h0);
        cin[1] = mk(1'b1, 1'b0, 1'b0, 10'h007, 32'h0);
        pulses = 0; pulse_at = -1; pulse_gnt1 = 0;
        for (int i = 1; i <= 20; i++) begin
            step(w);
            if (s_lock_err) begin
                pulses++; pulse_at = i; pulse_gnt1 = int'(s_gnt1);
            end
        end
        chk("r037_pulses", pulses, 1);
        chk("r037_when", pulse_at, LM + 1);
        chk("r037_c1gnt", pulse_gnt1, 1);
        cin[1] = '0;
        cin[0] = mk(1'b1, 1'b0, 1'b1, 10'h008, 32'h0);
        step(w);
        chk("r037_blkgnt", s_gnt0, 1'b1);
        cin[0] = mk(1'b0, 1'b0, 1'b1, 10'h000, 32'h0);
        cin[1] = mk(1'b1, 1'b0, 1'b0, 10'h009, 32'h0);
        step(w);
        chk("r037_nolock", s_gnt1, 1'b1);
        cin[0] = '0; cin[1] = '0;
        step(w);

        // reset during a read return discards it
        cin[1] = mk(1'b1, 1'b0, 1'b0, 10'h003, 32'h0);
        step(w);
        chk("r038_gnt", s_gnt1, 1'b1);
        RESET_N = 1'b0; m_reset();
        cin[0] = mk(1'b1, 1'b1, 1'b0, 10'h011, 32'hA5A5A5A5);
        for (int i = 0; i < 3; i++) begin
            step(w);
            chk("r038_rv", {s_rvalid1, s_gnt1, s_gnt0}, 3'b000);
        end
        RESET_N = 1'b1;
        cin[0] = '0; cin[1] = '0;
        step(w);
        chk("r038_after", s_rvalid1, 1'b0);

        // write then read of the same address
        cin[0] = mk(1'b1, 1'b1, 1'b0, 10'h020, 32'hCAFEF00D);
        step(w);
        cin[0] = '0;
        cin[1] = mk(1'b1, 1'b0, 1'b0, 10'h020, 32'h0);
        step(w);
        cin[1] = '0;
        step(w);
        chk("r039_rdata", s_rdata1, 32'hCAFEF00D);

        // random traffic with locks, held stable until granted
        for (int cyc = 0; cyc < 600; cyc++) begin
            step(w);
            for (int n = 0; n < 2; n++) begin
                if (m_owner == n && lk_left[n] > 0) lk_left[n]--;
                if (!cin[n].req || w == n) begin
                    rq = ($urandom_range(0, 2) != 0);
                    if (m_owner == n) begin
                        lk = (lk_left[n] > 0);
                    end else begin
                        lk = rq && ($urandom_range(0, 5) == 0);
                        if (lk) lk_left[n] = $urandom_range(1, 22);
                    end
                    cin[n] = mk(rq, 1'($urandom_range(0, 1)), lk,
                                10'($urandom_range(0, 15)), $urandom);
                end
            end
        end
        cin[0] = '0; cin[1] = '0;
        step(w); step(w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
